// File: rtl/ftdi_fifo_rd.sv
// FT245-style asynchronous FIFO read engine: waits for RXF#, strobes RD# for a fixed width,
// captures the byte at the end of the strobe, then holds RD# high for a precharge interval.
module ftdi_fifo_rd #(
  parameter int unsigned RD_LOW_CYC    = 3,
  parameter int unsigned PRECHARGE_CYC = 4,
  parameter int unsigned TIMEOUT_CYC   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iACT_RD_n,
  output logic       oRUN_RD_n,
  output logic       oDONE_RD_n,
  output logic       oTMO_RD_n,
  output logic [7:0] oRD_DATA,
  input  logic       iFIFO_RXF_n,
  output logic       oFIFO_RD_n,
  input  logic [7:0] iFIFO_DATA
);

  localparam logic [7:0]  RdLast  = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0]  PreLast = 8'(PRECHARGE_CYC - 1);
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);
  localparam bit          TmoEn   = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {StIdle, StWaitRxf, StStrobe, StPrechg} state_e;

  state_e      r_state, w_state_d;
  logic        r_rxf_meta, r_rxf_s;
  logic [15:0] r_wait_cnt, w_wait_cnt_d;
  logic [7:0]  r_str_cnt, w_str_cnt_d;
  logic [7:0]  r_pre_cnt, w_pre_cnt_d;
  logic        r_run_n, w_run_n_d;
  logic        r_done_n, w_done_n_d;
  logic        r_tmo_n, w_tmo_n_d;
  logic        r_rd_n, w_rd_n_d;
  logic [7:0]  r_rd_data, w_rd_data_d;
  logic        w_tmo_hit;

  assign w_tmo_hit = TmoEn && (r_wait_cnt == TmoLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_rxf_meta <= 1'b1;
      r_rxf_s    <= 1'b1;
      r_wait_cnt <= '0;
      r_str_cnt  <= '0;
      r_pre_cnt  <= '0;
      r_run_n    <= 1'b1;
      r_done_n   <= 1'b1;
      r_tmo_n    <= 1'b1;
      r_rd_n     <= 1'b1;
      r_rd_data  <= 8'h00;
    end else begin
      r_state    <= w_state_d;
      r_rxf_meta <= iFIFO_RXF_n;
      r_rxf_s    <= r_rxf_meta;
      r_wait_cnt <= w_wait_cnt_d;
      r_str_cnt  <= w_str_cnt_d;
      r_pre_cnt  <= w_pre_cnt_d;
      r_run_n    <= w_run_n_d;
      r_done_n   <= w_done_n_d;
      r_tmo_n    <= w_tmo_n_d;
      r_rd_n     <= w_rd_n_d;
      r_rd_data  <= w_rd_data_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (!iACT_RD_n) w_state_d = StWaitRxf;
      StWaitRxf: begin
        if (!r_rxf_s)       w_state_d = StStrobe;
        else if (w_tmo_hit) w_state_d = StIdle;
      end
      StStrobe:  if (r_str_cnt == RdLast) w_state_d = StPrechg;
      StPrechg:  if (r_pre_cnt == PreLast) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Next values for registered outputs and counters; pulse outputs default high.
  always_comb begin
    w_wait_cnt_d = r_wait_cnt;
    w_str_cnt_d  = r_str_cnt;
    w_pre_cnt_d  = r_pre_cnt;
    w_run_n_d    = r_run_n;
    w_done_n_d   = 1'b1;
    w_tmo_n_d    = 1'b1;
    w_rd_n_d     = r_rd_n;
    w_rd_data_d  = r_rd_data;
    case (r_state)
      StIdle: begin
        if (!iACT_RD_n) begin
          w_run_n_d    = 1'b0;
          w_wait_cnt_d = '0;
        end
      end
      StWaitRxf: begin
        if (!r_rxf_s) begin
          w_rd_n_d    = 1'b0;
          w_str_cnt_d = '0;
        end else if (w_tmo_hit) begin
          w_tmo_n_d = 1'b0;
          w_run_n_d = 1'b1;
        end else if (TmoEn) begin
          w_wait_cnt_d = r_wait_cnt + 16'd1;
        end
      end
      StStrobe: begin
        if (r_str_cnt == RdLast) begin
          w_rd_data_d = iFIFO_DATA;
          w_rd_n_d    = 1'b1;
          w_done_n_d  = 1'b0;
          w_pre_cnt_d = '0;
        end else begin
          w_str_cnt_d = r_str_cnt + 8'd1;
        end
      end
      StPrechg: begin
        if (r_pre_cnt == PreLast) w_run_n_d = 1'b1;
        else                      w_pre_cnt_d = r_pre_cnt + 8'd1;
      end
      default: ;
    endcase
  end

  assign oRUN_RD_n  = r_run_n;
  assign oDONE_RD_n = r_done_n;
  assign oTMO_RD_n  = r_tmo_n;
  assign oFIFO_RD_n = r_rd_n;
  assign oRD_DATA   = r_rd_data;

endmodule

// File: tb/tb_ftdi_fifo_rd.sv
// Directed bench for ftdi_fifo_rd: a per-cycle vector table for a basic read, then hand-written
// sequences for RXF# wait, back-to-back reads, timeout, mid-strobe reset and late data change.
module tb_ftdi_fifo_rd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       act_n = 1'b1, act_t = 1'b1;
  logic       drv_rxf = 1'b0, tmo_rxf = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       use_model = 1'b0;
  int         m_ptr = 0;

  logic       run_n, done_n, tmo_n, rd_n;
  logic [7:0] rd_data;
  logic       run_t, done_t, tmo_t, rd_t;
  logic [7:0] rd_data_t;
  logic       fifo_rxf;
  logic [7:0] fifo_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Three-byte FIFO model: each RD# rising edge pops one byte; empty after the third.
  always @(posedge rd_n) if (use_model) m_ptr <= m_ptr + 1;
  assign fifo_rxf  = use_model ? (m_ptr >= 3) : drv_rxf;
  assign fifo_data = use_model ? ((m_ptr < 3) ? 8'(m_ptr + 1) : 8'hFF) : drv_data;

  ftdi_fifo_rd u_dut (
    .clk        (clk),
    .rst        (rst),
    .iACT_RD_n  (act_n),
    .oRUN_RD_n  (run_n),
    .oDONE_RD_n (done_n),
    .oTMO_RD_n  (tmo_n),
    .oRD_DATA   (rd_data),
    .iFIFO_RXF_n(fifo_rxf),
    .oFIFO_RD_n (rd_n),
    .iFIFO_DATA (fifo_data)
  );

  ftdi_fifo_rd #(.TIMEOUT_CYC(16)) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .iACT_RD_n  (act_t),
    .oRUN_RD_n  (run_t),
    .oDONE_RD_n (done_t),
    .oTMO_RD_n  (tmo_t),
    .oRD_DATA   (rd_data_t),
    .iFIFO_RXF_n(tmo_rxf),
    .oFIFO_RD_n (rd_t),
    .iFIFO_DATA (drv_data)
  );

  typedef struct packed {
    logic       act_n;
    logic       rd_n;
    logic       run_n;
    logic       done_n;
    logic       tmo_n;
    logic [7:0] rd_data;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, n, strobes, dones, high_run, gap_min, n_tmo, tmo_at, rd_low, done_low;
    logic prev_rd, run_at_tmo;
    logic [7:0] got_q [$];

    //                 act  rd   run  done tmo  data
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5};

    // Reset state
    drv_data = 8'hA5;
    repeat (3) tick();
    check("rst_outputs", {rd_n, run_n, done_n, tmo_n, rd_data}, {4'hF, 8'h00});
    check("rst_outputs_t", {rd_t, run_t, done_t, tmo_t, rd_data_t}, {4'hF, 8'h00});
    rst = 1'b0;
    repeat (3) tick();

    // 1: basic read, table driven
    for (int i = 0; i < 10; i++) begin
      act_n = vecs[i].act_n;
      tick();
      check($sformatf("t1_vec%0d", i), {rd_n, run_n, done_n, tmo_n, rd_data},
            {vecs[i].rd_n, vecs[i].run_n, vecs[i].done_n, vecs[i].tmo_n, vecs[i].rd_data});
    end

    // 2: RXF# high for 10 cycles after the request
    drv_rxf = 1'b1;
    repeat (3) tick();
    act_n = 1'b0;
    tick();
    act_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t2_rd_high%0d", i), rd_n, 1'b1);
    end
    drv_rxf  = 1'b0;
    drv_data = 8'h3C;
    n = 0;
    while (rd_n !== 1'b0 && n < 8) begin
      tick();
      n++;
    end
    check_rng("t2_rd_fall_lat", n, 2, 3);
    k = 0;
    while (done_n !== 1'b0 && k < 15) begin
      tick();
      k++;
    end
    check("t2_done", done_n, 1'b0);
    check("t2_data", rd_data, 8'h3C);
    k = 0;
    while (run_n !== 1'b1 && k < 15) begin
      tick();
      k++;
    end
    check("t2_run_end", run_n, 1'b1);

    // 3: request held low, FIFO model supplies 01, 02, 03 then goes empty
    use_model = 1'b1;
    tick();
    act_n    = 1'b0;
    prev_rd  = 1'b1;
    strobes  = 0;
    dones    = 0;
    high_run = 0;
    gap_min  = 255;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done_n === 1'b0) begin
        dones++;
        got_q.push_back(rd_data);
      end
      if (rd_n === 1'b0) begin
        if (prev_rd === 1'b1) begin
          strobes++;
          if (strobes > 1 && high_run < gap_min) gap_min = high_run;
        end
        high_run = 0;
      end else begin
        high_run++;
      end
      prev_rd = rd_n;
    end
    act_n = 1'b1;
    check("t3_strobes", strobes, 3);
    check("t3_dones", dones, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t3_byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hXX, 8'(i + 1));
    check_rng("t3_gap_min", gap_min, 5, 254);
    use_model = 1'b0;
    drv_rxf   = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t3_post_rst_run", run_n, 1'b1);

    // 4: timeout instance; first a normal capture, then RXF# stuck high
    drv_data = 8'h5A;
    repeat (3) tick();
    act_t = 1'b0;
    tick();
    act_t = 1'b1;
    k = 0;
    while (done_t !== 1'b0 && k < 15) begin
      tick();
      k++;
    end
    check("t4_pre_done", done_t, 1'b0);
    check("t4_pre_data", rd_data_t, 8'h5A);
    k = 0;
    while (run_t !== 1'b1 && k < 15) begin
      tick();
      k++;
    end
    tmo_rxf  = 1'b1;
    drv_data = 8'hEE;
    repeat (3) tick();
    act_t = 1'b0;
    tick();
    act_t = 1'b1;
    n_tmo = 0; tmo_at = 0; rd_low = 0; done_low = 0; run_at_tmo = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (tmo_t === 1'b0) begin
        n_tmo++;
        tmo_at = c;
        run_at_tmo = run_t;
      end
      if (rd_t === 1'b0) rd_low++;
      if (done_t === 1'b0) done_low++;
    end
    check("t4_tmo_pulses", n_tmo, 1);
    check("t4_tmo_cycle", tmo_at, 16);
    check("t4_run_at_tmo", run_at_tmo, 1'b1);
    check("t4_rd_low", rd_low, 0);
    check("t4_done_low", done_low, 0);
    check("t4_data_kept", rd_data_t, 8'h5A);

    // 5: reset during the second strobe cycle
    drv_rxf  = 1'b0;
    drv_data = 8'h5C;
    repeat (3) tick();
    act_n = 1'b0;
    tick();
    act_n = 1'b1;
    tick();
    check("t5_strobe1", rd_n, 1'b0);
    tick();
    check("t5_strobe2", rd_n, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_out", {rd_n, run_n, done_n, tmo_n, rd_data}, {4'hF, 8'h00});
    n = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rd_n !== 1'b1 || run_n !== 1'b1 || done_n !== 1'b1) n++;
    end
    check("t5_idle_after_rst", n, 0);
    drv_data = 8'hC3;
    act_n = 1'b0;
    tick();
    act_n = 1'b1;
    k = 0;
    while (done_n !== 1'b0 && k < 15) begin
      tick();
      k++;
    end
    check("t5_new_done", done_n, 1'b0);
    check("t5_new_data", rd_data, 8'hC3);
    k = 0;
    while (run_n !== 1'b1 && k < 15) begin
      tick();
      k++;
    end

    // 6: data changes one cycle before the final strobe edge
    drv_data = 8'h11;
    tick();
    act_n = 1'b0;
    tick();
    act_n = 1'b1;
    repeat (3) tick();
    drv_data = 8'h77;
    tick();
    check("t6_done", done_n, 1'b0);
    check("t6_data", rd_data, 8'h77);
    drv_data = 8'h99;
    tick();
    check("t6_data_held", {done_n, rd_data}, {1'b1, 8'h77});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
